// File: rtl/hcms_29xx_pkg.sv
// Shared types and constants for the HCMS-29xx display-side receiver.
package hcms_29xx_pkg;

  localparam int unsigned DEF_NUM_COLS = 20;

  // Control word 0 layout
  localparam int unsigned CTRL0_W         = 7;
  localparam int unsigned CTRL0_PWM_LSB   = 0;
  localparam int unsigned CTRL0_PWM_W     = 4;
  localparam int unsigned CTRL0_PEAK_LSB  = 4;
  localparam int unsigned CTRL0_PEAK_W    = 2;
  localparam int unsigned CTRL0_SLEEP_BIT = 6;

  // Control word 1 layout and the bit that selects word 0 vs word 1
  localparam int unsigned CTRL1_W            = 2;
  localparam int unsigned CTRL1_SIMUL_BIT    = 0;
  localparam int unsigned CTRL1_PRESCALE_BIT = 1;
  localparam int unsigned CTRL_SEL_BIT       = 7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_CTRL   = 2'd2,
    ST_COMMIT = 2'd3
  } state_e;

  // Assemble a control word 0 from its fields
  function automatic logic [CTRL0_W-1:0] ctrl0_pack(input logic [CTRL0_PWM_W-1:0]  pwm,
                                                    input logic [CTRL0_PEAK_W-1:0] peak,
                                                    input logic                    sleep_n);
    logic [CTRL0_W-1:0] w;
    w = '0;
    w[CTRL0_PWM_LSB +: CTRL0_PWM_W]   = pwm;
    w[CTRL0_PEAK_LSB +: CTRL0_PEAK_W] = peak;
    w[CTRL0_SLEEP_BIT]                = sleep_n;
    return w;
  endfunction

  // Power-up state of the display: brightness 12, awake, lowest peak current
  localparam logic [CTRL0_W-1:0] CTRL0_RST = ctrl0_pack(4'd12, 2'd0, 1'b1);

endpackage

// File: rtl/hcms_29xx_rx_sync.sv
// Multi-flop synchronizer with edge pulses; level_o is the sample the pulses refer to.
module hcms_29xx_sync #(
  parameter int unsigned WIDTH   = 1,
  parameter int unsigned STAGES  = 2,
  parameter bit          FALL_EN = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] level_o,
  output logic [WIDTH-1:0] rise_c_o,
  output logic [WIDTH-1:0] fall_c_o
);

  logic [WIDTH-1:0] sync_q [STAGES];
  logic [WIDTH-1:0] prev_q;

  // Synchronizer chain plus one history flop for edge detection
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < int'(STAGES); i++) sync_q[i] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < int'(STAGES); i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level_o  = sync_q[STAGES-1];
  assign rise_c_o = sync_q[STAGES-1] & ~prev_q;

  generate
    if (FALL_EN) begin : g_fall
      assign fall_c_o = ~sync_q[STAGES-1] & prev_q;
    end else begin : g_no_fall
      assign fall_c_o = '0;
    end
  endgenerate

endmodule

// File: rtl/hcms_29xx_rx.sv
// HCMS-29xx display-side receiver: emulates the dot shift register and control
// registers, streaming latched columns out one per cycle.
// Optional: define HCMS_RX_DOUT_EN to drive DOUT_o as a cascade output.
module hcms_29xx_rx
  import hcms_29xx_pkg::*;
#(
  parameter int unsigned NUM_COLS    = DEF_NUM_COLS,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               CLK_i,
  input  logic               RST_N_i,
  input  logic               SCLK_i,
  input  logic               DIN_i,
  input  logic               RS_i,
  input  logic               CE_N_i,
  output logic               DOT_WR_o,
  output logic [4:0]         DOT_ADDR_o,
  output logic [7:0]         DOT_DATA_o,
  output logic [CTRL0_W-1:0] CTRL0_o,
  output logic [CTRL1_W-1:0] CTRL1_o,
  output logic               BUSY_o,
  output logic               FRAME_ERR_o,
  output logic               DOUT_o
);

  localparam int unsigned NB    = NUM_COLS * 8;
  localparam int unsigned CNT_W = $clog2(NB + 1);
  localparam int unsigned COL_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(NB);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(NUM_COLS - 1);

`ifdef HCMS_RX_DOUT_EN
  localparam bit SCLK_FALL_EN = 1'b1;
`else
  localparam bit SCLK_FALL_EN = 1'b0;
`endif

  // Synchronized inputs; DIN rides with SCLK so it is sampled at the same instant
  logic [1:0] sd_lvl, sd_rise, sd_fall;
  logic       cen_lvl, cen_rise, cen_fall;
  logic       rs_lvl, rs_rise, rs_fall;
  logic       sclk_rise, din_s;

  hcms_29xx_sync #(.WIDTH(2), .STAGES(SYNC_STAGES), .FALL_EN(SCLK_FALL_EN)) u_sync_sclk (
    .clk_i   (CLK_i),
    .rst_n_i (RST_N_i),
    .d_i     ({SCLK_i, DIN_i}),
    .level_o (sd_lvl),
    .rise_c_o(sd_rise),
    .fall_c_o(sd_fall)
  );

  hcms_29xx_sync #(.WIDTH(1), .STAGES(SYNC_STAGES), .FALL_EN(1'b1)) u_sync_cen (
    .clk_i   (CLK_i),
    .rst_n_i (RST_N_i),
    .d_i     (CE_N_i),
    .level_o (cen_lvl),
    .rise_c_o(cen_rise),
    .fall_c_o(cen_fall)
  );

  hcms_29xx_sync #(.WIDTH(1), .STAGES(SYNC_STAGES), .FALL_EN(1'b0)) u_sync_rs (
    .clk_i   (CLK_i),
    .rst_n_i (RST_N_i),
    .d_i     (RS_i),
    .level_o (rs_lvl),
    .rise_c_o(rs_rise),
    .fall_c_o(rs_fall)
  );

  assign sclk_rise = sd_rise[1];
  assign din_s     = sd_lvl[0];

  logic unused_sync;
  assign unused_sync = ^{sd_lvl[1], sd_rise[0], sd_fall, cen_lvl, rs_rise, rs_fall};

  state_e             state_q, state_d;
  logic               rs_q, rs_d;
  logic               pend_q, pend_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [NB-1:0]      shreg_q, shreg_d;
  logic [NB-1:0]      latch_q, latch_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic               dot_wr_q, dot_wr_d;
  logic [4:0]         dot_addr_q, dot_addr_d;
  logic [7:0]         dot_data_q, dot_data_d;
  logic [CTRL0_W-1:0] ctrl0_q, ctrl0_d;
  logic [CTRL1_W-1:0] ctrl1_q, ctrl1_d;
  logic               busy_q, busy_d;
  logic               ferr_q, ferr_d;

  // State register
  always_ff @(posedge CLK_i or negedge RST_N_i) begin
    if (!RST_N_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (cen_fall || pend_q) state_d = ST_SHIFT;
      ST_SHIFT:  if (cen_rise) state_d = rs_q ? ST_CTRL : ST_COMMIT;
      ST_CTRL:   state_d = ST_IDLE;
      ST_COMMIT: if (col_q == COL_LAST) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    rs_d       = rs_q;
    pend_d     = pend_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    latch_d    = latch_q;
    col_d      = col_q;
    dot_wr_d   = 1'b0;
    dot_addr_d = dot_addr_q;
    dot_data_d = dot_data_q;
    ctrl0_d    = ctrl0_q;
    ctrl1_d    = ctrl1_q;
    busy_d     = 1'b0;
    ferr_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cen_fall || pend_q) begin
          rs_d      = rs_lvl;
          bit_cnt_d = '0;
          pend_d    = 1'b0;
        end
      end
      ST_SHIFT: begin
        // Shift first so a bit coincident with the CE_N rise is included
        if (sclk_rise) begin
          shreg_d = {shreg_q[NB-2:0], din_s};
          if (bit_cnt_q != CNT_MAX) bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
        if (cen_rise && !rs_q) begin
          latch_d = shreg_d;
          col_d   = '0;
        end
      end
      ST_CTRL: begin
        if (cen_fall) pend_d = 1'b1;
        if (bit_cnt_q < CNT_W'(8)) begin
          ferr_d = 1'b1;
        end else if (shreg_q[CTRL_SEL_BIT]) begin
          ctrl1_d[CTRL1_SIMUL_BIT]    = shreg_q[CTRL1_SIMUL_BIT];
          ctrl1_d[CTRL1_PRESCALE_BIT] = shreg_q[CTRL1_PRESCALE_BIT];
        end else begin
          ctrl0_d = shreg_q[CTRL0_W-1:0];
        end
      end
      ST_COMMIT: begin
        // Oldest byte sits at the top of the latch; shift it out column by column
        if (cen_fall) pend_d = 1'b1;
        dot_wr_d   = 1'b1;
        busy_d     = 1'b1;
        dot_addr_d = 5'(col_q);
        dot_data_d = latch_q[NB-1 -: 8];
        latch_d    = latch_q << 8;
        col_d      = (col_q == COL_LAST) ? '0 : col_q + COL_W'(1);
        if (sclk_rise) ferr_d = 1'b1;
        if ((col_q == '0) && ((bit_cnt_q == '0) || (bit_cnt_q[2:0] != 3'd0))) ferr_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge CLK_i or negedge RST_N_i) begin
    if (!RST_N_i) begin
      rs_q       <= 1'b0;
      pend_q     <= 1'b0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      latch_q    <= '0;
      col_q      <= '0;
      dot_wr_q   <= 1'b0;
      dot_addr_q <= '0;
      dot_data_q <= '0;
      ctrl0_q    <= CTRL0_RST;
      ctrl1_q    <= '0;
      busy_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      rs_q       <= rs_d;
      pend_q     <= pend_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      latch_q    <= latch_d;
      col_q      <= col_d;
      dot_wr_q   <= dot_wr_d;
      dot_addr_q <= dot_addr_d;
      dot_data_q <= dot_data_d;
      ctrl0_q    <= ctrl0_d;
      ctrl1_q    <= ctrl1_d;
      busy_q     <= busy_d;
      ferr_q     <= ferr_d;
    end
  end

  assign DOT_WR_o    = dot_wr_q;
  assign DOT_ADDR_o  = dot_addr_q;
  assign DOT_DATA_o  = dot_data_q;
  assign CTRL0_o     = ctrl0_q;
  assign CTRL1_o     = ctrl1_q;
  assign BUSY_o      = busy_q;
  assign FRAME_ERR_o = ferr_q;

`ifdef HCMS_RX_DOUT_EN
  logic dout_q;

  // Cascade output: register MSB on each SCLK fall
  always_ff @(posedge CLK_i or negedge RST_N_i) begin
    if (!RST_N_i)        dout_q <= 1'b0;
    else if (sd_fall[1]) dout_q <= shreg_q[NB-1];
  end

  assign DOUT_o = dout_q;
`else
  assign DOUT_o = 1'b0;
`endif

endmodule

// File: doc/hcms_29xx_rx.md
Name: hcms_29xx_rx

Overview:
- Display-side responder for the HCMS-29xx serial interface driven by hcms_serial; emulates the display's input shift register and its control registers.
- Oversamples DIN/SCLK/RS/CE_N on CLK_i and latches dot data or control words on the CE_N rising edge.
- Streams latched columns to a display emulator / scoreboard.
- Used on-board as a loopback checker and in benches as the protocol monitor.

Parameters:
NUM_COLS, 20, display columns; dot register = NUM_COLS*8 bits
SYNC_STAGES, 2, synchronizer flops on each serial input (>=2)

Ports:
CLK_i  in  1  system clock
RST_N_i  in  1  asynchronous active-low reset
SCLK_i  in  1  display serial clock (async to CLK_i)
DIN_i  in  1  serial data, sampled on SCLK_i rising edge
RS_i  in  1  register select: 0 = dot register, 1 = control register
CE_N_i  in  1  chip enable, active low; rising edge latches
DOT_WR_o  out  1  column write strobe
DOT_ADDR_o  out  5  column index 0..NUM_COLS-1
DOT_DATA_o  out  8  column bits; bit7 = first bit shifted for that column
CTRL0_o  out  7  control word 0 bits[6:0]: [3:0] PWM brightness, [5:4] peak current, [6] sleep_n
CTRL1_o  out  2  control word 1 bits[1:0]: [0] simultaneous/serial, [1] prescaler
BUSY_o  out  1  high while streaming columns
FRAME_ERR_o  out  1  one-cycle pulse on protocol error
DOUT_o  out  1  serial cascade output (see optional feature)

Behaviour:
- Reset: all outputs 0, except CTRL0_o = 7'b1001100 (brightness 12, sleep_n = 1, peak current 00). Shift register, bit counter and FSM are cleared; state = IDLE.
- Inputs pass through hcms_29xx_sync: SYNC_STAGES flops plus edge detect. Edge-to-action latency = SYNC_STAGES+1 CLK_i cycles.
- Legal input timing: SCLK high and low each >= SYNC_STAGES+1 CLK_i cycles.
- FSM states:
  - IDLE: on CE_N fall, capture RS into rs_q, clear bit_cnt -> SHIFT.
  - SHIFT: each SCLK rise shifts DIN into shreg[0]; shreg is NUM_COLS*8 bits. Bits beyond capacity fall off the top, as on the real device.
    - bit_cnt saturates at NUM_COLS*8; SCLK rises while CE_N is high are ignored.
    - On CE_N rise: if rs_q = 1 -> CTRL, else -> COMMIT.
  - CTRL: the last 8 bits (shreg[7:0]) form the word. The word's bit7 selects the target: 0 -> CTRL0_o <= word[6:0]; 1 -> CTRL1_o <= word[1:0]. Control word 1 bits [6:2] are ignored.
    - If bit_cnt < 8: no update and FRAME_ERR_o pulses.
    - Returns to IDLE after 1 cycle.
  - COMMIT: snapshot shreg into a latch register. Emit column k, for k = 0..NUM_COLS-1, one per cycle: DOT_ADDR_o = k, DOT_DATA_o = latch[NUM_COLS*8-1-8k -: 8], DOT_WR_o = 1. BUSY_o is high throughout.
    - Column 0 = oldest surviving byte.
    - Then -> IDLE.
    - If bit_cnt is not a multiple of 8, or is 0, FRAME_ERR_o pulses in the first COMMIT cycle and the columns are still streamed.
- Simultaneous events:
  - A CE_N fall arriving during COMMIT is held and processed on the first IDLE cycle.
  - SCLK rises during COMMIT are dropped, each pulsing FRAME_ERR_o.
  - A CE_N rise coincident with an SCLK rise: the bit is shifted first, then the latch happens.
- RST_N_i low mid-frame aborts immediately. Partial data is discarded and no DOT_WR_o or control update occurs.

Optional Feature:
HCMS_RX_DOUT_EN
- Defined: DOUT_o = shreg MSB, registered and updated on each SCLK fall, for cascading a second hcms_29xx_rx.
- Undefined: DOUT_o tied 0 and the falling-edge detect logic is removed.

Decomposition:
- Package hcms_29xx_pkg holds:
  - FSM state enum (IDLE, SHIFT, CTRL, COMMIT)
  - CTRL0 reset value and field bit positions (PWM, PEAK, SLEEP)
  - CTRL1 field positions and the control-select bit index (7)
  - default NUM_COLS
- Sub-module hcms_29xx_sync: parameterised multi-flop synchronizer with rise/fall pulse outputs, instantiated for SCLK_i, CE_N_i and RS_i, DIN_i sampled alongside.

Test Plan:
- Reset release -> CTRL0_o = 7'h4C, CTRL1_o = 0, DOT_WR_o and FRAME_ERR_o never pulse while idle.
- RS=1, shift 8'b10000001 (as hcms_serial config word 1), then CE_N rise -> CTRL1_o = 2'b01, CTRL0_o unchanged, no FRAME_ERR_o.
- RS=1, shift 8'b01111001 -> CTRL0_o = 7'h79. Then RS=1 with only 5 bits -> FRAME_ERR_o single pulse, CTRL0_o stays 7'h79.
- RS=0, shift bytes 0x00..0x13 (160 bits) -> 20 consecutive DOT_WR_o cycles with ADDR k and DATA k, BUSY_o high for 20 cycles.
- RS=0, shift 168 bits (0xFF, then 0x01..0x14) -> first byte discarded, columns 0..19 = 0x01..0x14. Then a 12-bit frame -> FRAME_ERR_o pulse plus 20 column writes.
- Assert RST_N_i mid-way through a 160-bit frame, release, then CE_N rise -> no DOT_WR_o, outputs at reset values. With HCMS_RX_DOUT_EN defined, DOUT_o replays DIN delayed by 160 SCLK edges.
